// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared opcodes, frame lengths and FSM states for the SPI RAM responder
package spi_ram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam int         CMD_BITS  = 8;
    localparam int         ADDR_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_DATA,
        WR_DATA,
        IGNORE
    } state_e;

endpackage

// File: rtl/spi_ram_responder_if.sv
// rtl/spi_ram_responder_if.sv - SPI pins plus status pulses between master and RAM responder
interface spi_ram_responder_if;

    logic spi_cs_n;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;
    logic txn_done;
    logic cmd_err;

    modport master (
        output spi_cs_n, spi_sck, spi_mosi,
        input  spi_miso, spi_miso_oe, txn_done, cmd_err
    );

    modport slave (
        input  spi_cs_n, spi_sck, spi_mosi,
        output spi_miso, spi_miso_oe, txn_done, cmd_err
    );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with single-cycle rise/fall pulses
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - SPI mode-0 target serving READ/WRITE bursts from an internal byte array
import spi_ram_pkg::*;

module spi_ram_responder #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rst_n,
    spi_ram_responder_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi;

    state_e            state_q, state_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [6:0]        shift_q, shift_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        tx_q, tx_d;
    logic              load_q, load_d;
    logic              miso_q, miso_d;
    logic              txn_done_q, txn_done_d;
    logic              cmd_err_q, cmd_err_d;
    logic              mem_we;
    logic [7:0]        rx_byte;
    logic [7:0]        rdata_q;
    logic [7:0]        mem_q [DEPTH];

    // cs_n sync resets low so a frame already running when reset lifts
    // produces no fall and is ignored until CS goes high and low again.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .d_i(bus.spi_sck), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .d_i(bus.spi_cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    end

    assign mosi    = mosi_sync_q[SYNC_STAGES-1];
    assign rx_byte = {shift_q, mosi};

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rd_d       = rd_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        load_d     = 1'b0;
        miso_d     = miso_q;
        txn_done_d = 1'b0;
        cmd_err_d  = 1'b0;
        mem_we     = 1'b0;

        if (load_q) tx_d = rdata_q;

        if (cs_rise) begin
            state_d    = IDLE;
            bitcnt_d   = '0;
            shift_d    = '0;
            miso_d     = 1'b0;
            txn_done_d = (state_q == RD_DATA) || (state_q == WR_DATA);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d  = CMD;
                        bitcnt_d = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        shift_d  = {shift_q[5:0], mosi};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'(CMD_BITS - 1)) begin
                            bitcnt_d = '0;
                            if (rx_byte == CMD_READ) begin
                                state_d = ADDR;
                                rd_d    = 1'b1;
                            end else if (rx_byte == CMD_WRITE) begin
                                state_d = ADDR;
                                rd_d    = 1'b0;
                            end else begin
                                state_d   = IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    // Upper address bits simply shift out of the index register.
                    if (sck_rise) begin
                        idx_d    = {idx_q[ADDR_W-2:0], mosi};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'(ADDR_BITS - 1)) begin
                            bitcnt_d = '0;
                            state_d  = rd_q ? RD_DATA : WR_DATA;
                            load_d   = rd_q;
                        end
                    end
                end
                RD_DATA: begin
                    if (sck_fall) begin
                        miso_d   = tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            bitcnt_d = '0;
                            idx_d    = idx_q + ADDR_W'(1);
                            load_d   = 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (sck_rise) begin
                        shift_d  = {shift_q[5:0], mosi};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            bitcnt_d = '0;
                            mem_we   = 1'b1;
                            idx_d    = idx_q + ADDR_W'(1);
                        end
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            rd_q       <= 1'b0;
            idx_q      <= '0;
            tx_q       <= '0;
            load_q     <= 1'b0;
            miso_q     <= 1'b0;
            txn_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            rd_q       <= rd_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            load_q     <= load_d;
            miso_q     <= miso_d;
            txn_done_q <= txn_done_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // Reading at the next index lets the tx register load one cycle after a
    // prefetch request, well inside the minimum SCK phase.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) mem_q[idx_q] <= rx_byte;
        rdata_q <= mem_q[idx_d];
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = (state_q == RD_DATA);
    assign bus.txn_done    = txn_done_q;
    assign bus.cmd_err     = cmd_err_q;

endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
SPI-mode-0 target that emulates the external instruction/data RAM the CPU fetch path reads from. It decodes READ (0x03) and WRITE (0x02) commands with a 16-bit address and serves bytes from an internal byte array. It lets the full CPU + SPI master loop run in simulation and on FPGA without the RP2040 emulator. It runs on the system clock and oversamples SCK, CS_n and MOSI.

Parameters:
ADDR_W, 8, internal array index width; DEPTH = 2**ADDR_W bytes
SYNC_STAGES, 2, synchroniser flops on cs_n/sck/mosi (min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
spi_cs_n  in  1  chip select from master, active low
spi_sck  in  1  serial clock from master, idle low
spi_mosi  in  1  master-out data, MSB first
spi_miso  out  1  target-out data, MSB first
spi_miso_oe  out  1  high while target drives MISO (read data phase)
txn_done  out  1  1-cycle pulse: CS deasserted after a complete cmd+addr phase
cmd_err  out  1  1-cycle pulse: 8th command bit received, opcode not 0x02/0x03

Behaviour:
- Reset: rst_n is synchronous and active-low; clk is the clock. Reset forces state IDLE, bit counter 0, shift registers 0, spi_miso 0, spi_miso_oe 0, txn_done 0, cmd_err 0. Array contents are not reset.
- Input conditioning: cs_n, sck and mosi each pass through SYNC_STAGES flops.
  - Rise/fall detect on synced sck, using one more flop.
  - Edge events lag pins by SYNC_STAGES+1 clk.
  - Legal use: SCK high and low phases each >= 4 clk.
- Protocol, mode 0:
  - Sample MOSI on detected SCK rise.
  - Update MISO on detected SCK fall.
  - Frame = 8-bit cmd, 16-bit addr (big-endian), then data bytes while CS low.
- States:
  - IDLE: on synced cs_n fall -> CMD, bitcnt = 0.
  - CMD: shift 8 bits. On 8th: 0x03 -> ADDR(rd); 0x02 -> ADDR(wr); else pulse cmd_err -> IGNORE.
  - ADDR: shift 16 bits. Array index = addr[ADDR_W-1:0]; upper bits ignored.
    - On 16th bit, read: issue array read; load tx shift reg before the next SCK fall (1-cycle synchronous read fits the 4-clk margin); -> RD_DATA.
    - On 16th bit, write: -> WR_DATA.
  - RD_DATA:
    - spi_miso_oe = 1.
    - On each SCK fall: spi_miso = tx[7], tx shifts left.
    - The first fall after the last addr bit presents bit 7 of mem[addr].
    - After 8 falls: index += 1 (wraps mod DEPTH), prefetch the next byte. Burst continues indefinitely.
  - WR_DATA:
    - Shift 8 bits.
    - On 8th rise: mem[index] <= byte; index += 1 (wrap).
    - Partial bytes are never written.
  - IGNORE: discard all bits until CS high.
- CS deassert (synced rising cs_n) in any state:
  - -> IDLE next clk; bitcnt cleared; spi_miso 0; spi_miso_oe 0.
  - Pending partial write byte is discarded.
  - txn_done pulses if the addr phase had completed.
- CS high with SCK toggling: ignored.
- CS deassert and SCK edge in the same clk: CS wins; the edge is dropped.
- spi_miso outside RD_DATA: 0.
- Reset mid-frame: abort to IDLE. The next frame needs a fresh CS fall; a frame already in progress when reset lifts is ignored until CS goes high.

Decomposition:
- Package spi_ram_pkg:
  - CMD_READ = 8'h03, CMD_WRITE = 8'h02
  - CMD_BITS = 8, ADDR_BITS = 16
  - state enum {IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE}
- Sub-module spi_sync_edge: parameterised synchroniser plus rise/fall pulse generator. Instantiated for sck and cs_n; mosi uses the sync only.
- Array is inferred in the top module.

Test Plan:
- WRITE 0x02, addr 0x0010, data 0xA5 then 0x3C, CS high. Then READ 0x03 at 0x0010 for 2 bytes -> MISO returns 0xA5, 0x3C; txn_done pulses once per frame.
- Fill 0x00..0x03 with 0x11,0x22,0x33,0x44. Run two separate 1-byte READs at 0x0000 and 0x0001 (opcode-then-operand pattern) -> 0x11 then 0x22; spi_miso_oe high only during data bits.
- ADDR_W=8. WRITE 0x0100 data 0x77 -> lands at index 0x00. Then READ burst at 0x00FF for 2 bytes -> mem[0xFF], then 0x77 (wrap).
- Command 0x9F plus 24 clocks -> cmd_err pulses once; MISO stays 0 and oe 0; no array change; txn_done not asserted.
- WRITE at 0x0020 prior value 0x55; send 5 data bits 10101, CS high -> mem[0x20] still 0x55. A following READ works normally.
- Assert rst_n low for 1 clk mid-address of a READ; keep clocking SCK, then raise CS. The next full READ at 0x0010 returns 0xA5 and spi_miso is 0 throughout the aborted frame.
